// File: rtl/intt.sv
// Inverse NTT over Z_Q: loads N coefficients as pairs, runs DEPTH-1 Gentleman-Sande
//   layers through a 4-stage butterfly pipeline, then streams out pairs scaled by NINV.
// Ports: clk/reset (sync, active-high); start, in_valid, in_data_1/2 (load side);
//   zeta_addr/zeta (external ROM, 1-cycle read); busy; out_valid/out_ready/out_data_1/2.
// Backpressure: the load side is never stalled; out_valid holds its pair until out_ready.
module intt #(
    parameter int DEPTH = 8,
    parameter int Q     = 3329,
    parameter int NINV  = 3303
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    input  logic [15:0]        in_data_1,
    input  logic [15:0]        in_data_2,
    output logic [6:0]         zeta_addr,
    input  logic signed [15:0] zeta,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        out_data_1,
    output logic [15:0]        out_data_2
);
    localparam int N    = 1 << DEPTH;
    localparam int HALF = N / 2;
    localparam int AW   = DEPTH;
    localparam int CW   = DEPTH - 1;
    localparam int LW   = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST_C  = CW'(HALF - 1);
    localparam logic [CW-1:0] K_START = CW'((1 << (DEPTH - 1)) - 1);
    localparam logic [16:0]   Q17     = 17'(Q);
    localparam logic [15:0]   Q16     = 16'(Q);
    localparam logic [31:0]   QW      = 32'(Q);
    localparam logic [31:0]   NW      = 32'(NINV);
    // The final layer (DEPTH-1) writes RAM2 when odd, RAM1 when even.
    localparam logic RES_RAM2 = ((DEPTH - 1) % 2) == 1;

    typedef enum logic [2:0] {IDLE, LOAD, CALC, DRAIN, OUT} state_t;
    state_t state, state_nx;

    logic [CW-1:0] ld_cnt, bf_cnt, k, rd_ptr, out_cnt;
    logic [LW-1:0] lyr;
    logic [1:0]    drn_cnt;
    logic          pend, rd_done;

    logic [15:0] ram1 [N];
    logic [15:0] ram2 [N];
    logic [15:0] ram1_q0, ram1_q1, ram2_q0, ram2_q1;

    // pipeline: p1 = RAM/ROM data visible, p2 = sum/diff, p3 = product, p4 = write
    logic          p1_v, p2_v, p3_v, p4_v;
    logic [AW-1:0] p1_ja, p1_jb, p2_ja, p2_jb, p3_ja, p3_jb, p4_ja, p4_jb;
    logic          p1_src1, p2_dst2, p3_dst2, p4_dst2;
    logic [15:0]   p2_sum, p2_diff, p2_zeta, p3_sum, p4_sum, p4_t;
    logic [31:0]   p3_prod;

    logic          last_ld, last_bf, last_lyr, last_out, iss, out_iss, grp_end, rd_en;
    logic [AW-1:0] c_ext, len_w, off, ja, jb, rd_a, rd_b, wa0, wa1;
    logic [15:0]   wd0, wd1, a, b, diff, sum_m, f0, f1;
    logic [16:0]   sum17;
    logic          load_we, ram1_we, ram2_we;

    assign last_ld  = (ld_cnt == LAST_C);
    assign last_bf  = (bf_cnt == LAST_C);
    assign last_out = (out_cnt == LAST_C);
    assign last_lyr = (lyr == LW'(DEPTH - 1));
    assign busy     = (state != IDLE);
    assign iss      = (state == CALC);
    // One readout in flight at a time; only fetch when the output register frees up.
    assign out_iss  = (state == OUT) && !pend && !rd_done && (!out_valid || out_ready);
    assign rd_en    = iss || out_iss;

    // Butterfly c of a layer with len = 2^lyr: j = group*2*len + offset, partner j+len.
    assign c_ext   = {1'b0, bf_cnt};
    assign len_w   = AW'(1) << lyr;
    assign off     = c_ext & (len_w - AW'(1));
    assign ja      = (((c_ext >> lyr) << lyr) << 1) | off;
    assign jb      = ja | len_w;
    assign grp_end = (off == (len_w - AW'(1)));

    // ROM data arrives with the RAM data one cycle after issue, so k drives it directly.
    assign zeta_addr = iss ? 7'(k) : 7'd0;

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (iss) begin
            rd_a = ja;
            rd_b = jb;
        end else if (state == OUT) begin
            rd_a = {rd_ptr, 1'b0};
            rd_b = {rd_ptr, 1'b1};
        end
    end

    assign load_we = (state == LOAD) && in_valid;
    assign wa0     = load_we ? {ld_cnt, 1'b0} : p4_ja;
    assign wa1     = load_we ? {ld_cnt, 1'b1} : p4_jb;
    assign wd0     = load_we ? in_data_1 : p4_sum;
    assign wd1     = load_we ? in_data_2 : p4_t;
    assign ram1_we = load_we || (p4_v && !p4_dst2);
    assign ram2_we = p4_v && p4_dst2;

    always_ff @(posedge clk) begin
        if (ram1_we) begin
            ram1[wa0] <= wd0;
            ram1[wa1] <= wd1;
        end
        if (rd_en) begin
            ram1_q0 <= ram1[rd_a];
            ram1_q1 <= ram1[rd_b];
        end
    end

    always_ff @(posedge clk) begin
        if (ram2_we) begin
            ram2[wa0] <= wd0;
            ram2[wa1] <= wd1;
        end
        if (rd_en) begin
            ram2_q0 <= ram2[rd_a];
            ram2_q1 <= ram2[rd_b];
        end
    end

    // Butterfly arithmetic on the p1 stage
    assign a     = p1_src1 ? ram1_q0 : ram2_q0;
    assign b     = p1_src1 ? ram1_q1 : ram2_q1;
    assign sum17 = {1'b0, a} + {1'b0, b};
    assign sum_m = (sum17 >= Q17) ? 16'(sum17 - Q17) : 16'(sum17);
    assign diff  = (b >= a) ? (b - a) : (b + Q16 - a);

    always_ff @(posedge clk) begin
        p2_ja   <= p1_ja;
        p2_jb   <= p1_jb;
        p2_dst2 <= p1_src1;
        p2_sum  <= sum_m;
        p2_diff <= diff;
        p2_zeta <= 16'(zeta);
        p3_ja   <= p2_ja;
        p3_jb   <= p2_jb;
        p3_dst2 <= p2_dst2;
        p3_sum  <= p2_sum;
        p3_prod <= 32'(p2_zeta) * 32'(p2_diff);
        p4_ja   <= p3_ja;
        p4_jb   <= p3_jb;
        p4_dst2 <= p3_dst2;
        p4_sum  <= p3_sum;
        p4_t    <= 16'(p3_prod % QW);
    end

    // FSM
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    if (in_valid && last_ld) state_nx = CALC;
            CALC:    if (last_bf) state_nx = DRAIN;
            // Four drain cycles cover the last write of the layer before the next read.
            DRAIN:   if (drn_cnt == 2'd3) state_nx = last_lyr ? OUT : CALC;
            OUT:     if (out_valid && out_ready && last_out) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Counters and pipeline valids
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_cnt  <= '0;
            bf_cnt  <= '0;
            k       <= '0;
            lyr     <= '0;
            drn_cnt <= '0;
            p1_v    <= 1'b0;
            p2_v    <= 1'b0;
            p3_v    <= 1'b0;
            p4_v    <= 1'b0;
        end else begin
            p1_v <= iss;
            p2_v <= p1_v;
            p3_v <= p2_v;
            p4_v <= p3_v;
            case (state)
                IDLE: ld_cnt <= '0;
                LOAD: if (in_valid) begin
                    ld_cnt <= ld_cnt + CW'(1);
                    if (last_ld) begin
                        bf_cnt <= '0;
                        lyr    <= LW'(1);
                        k      <= K_START;
                    end
                end
                CALC: begin
                    bf_cnt  <= last_bf ? '0 : bf_cnt + CW'(1);
                    drn_cnt <= '0;
                    if (grp_end) k <= k - CW'(1);
                end
                DRAIN: begin
                    drn_cnt <= drn_cnt + 2'd1;
                    if (drn_cnt == 2'd3 && !last_lyr) lyr <= lyr + LW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        p1_ja   <= ja;
        p1_jb   <= jb;
        p1_src1 <= lyr[0];
    end

    // Readout: scale the returned pair and hold it until accepted
    assign f0 = RES_RAM2 ? ram2_q0 : ram1_q0;
    assign f1 = RES_RAM2 ? ram2_q1 : ram1_q1;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data_1 <= '0;
            out_data_2 <= '0;
            pend       <= 1'b0;
            rd_ptr     <= '0;
            rd_done    <= 1'b0;
            out_cnt    <= '0;
        end else if (state == IDLE) begin
            out_valid <= 1'b0;
            pend      <= 1'b0;
            rd_ptr    <= '0;
            rd_done   <= 1'b0;
            out_cnt   <= '0;
        end else begin
            pend <= out_iss;
            if (out_iss) begin
                rd_ptr <= rd_ptr + CW'(1);
                if (rd_ptr == LAST_C) rd_done <= 1'b1;
            end
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_cnt   <= out_cnt + CW'(1);
            end
            if (pend) begin
                out_valid  <= 1'b1;
                out_data_1 <= 16'((32'(f0) * NW) % QW);
                out_data_2 <= 16'((32'(f1) * NW) % QW);
            end
        end
    end
endmodule
